// File: rtl/rsa_modexp_seq.sv
// +--------------------------------------------------------------------------+
// | rsa_modexp_seq : sequential base^exp mod modulus, right-to-left          |
// | square-and-multiply over bit-serial interleaved mulmod datapaths.        |
// | Optional build macro: MODEXP_EARLY_EXIT_EN (stop once exponent is spent). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module rsa_modexp_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int            CW   = $clog2(WIDTH);
  localparam int            TW   = WIDTH + 2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_MULT = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [TW-1:0]    sq_q, sq_d;
  logic [TW-1:0]    pr_q, pr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [CW-1:0]    idx;
  logic [TW-1:0]    sq_step;
  logic [TW-1:0]    pr_step;
  logic [TW-1:0]    red_step;
  logic [WIDTH-1:0] e_next;
  logic             mult_exit;

  // One interleaved mulmod step: t < n on entry guarantees 2t + a < 3n.
  function automatic logic [TW-1:0] mm_step(
    input logic [TW-1:0]    t,
    input logic [WIDTH-1:0] a,
    input logic             sel,
    input logic [WIDTH-1:0] n
  );
    logic [TW-1:0] s;
    logic [TW-1:0] nn;
    nn = {2'b00, n};
    s  = {t[TW-2:0], 1'b0} + (sel ? {2'b00, a} : '0);
    if (s >= nn) s = s - nn;
    if (s >= nn) s = s - nn;
    return s;
  endfunction

  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    acc_d    = acc_q;
    e_d      = e_q;
    n_d      = n_q;
    sq_d     = sq_q;
    pr_d     = pr_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    result_d = result_q;

    // Multiplier bits are consumed MSB first.
    idx      = LAST - cnt_q;
    sq_step  = mm_step(sq_q, b_q, b_q[idx], n_q);
    pr_step  = mm_step(pr_q, b_q, acc_q[idx], n_q);
    red_step = {sq_q[TW-2:0], b_q[WIDTH-1]};
    if (red_step >= {2'b00, n_q}) red_step = red_step - {2'b00, n_q};
    e_next   = e_q >> 1;
`ifdef MODEXP_EARLY_EXIT_EN
    mult_exit = (e_next == '0) || (bitcnt_q == LAST);
`else
    mult_exit = (bitcnt_q == LAST);
`endif

    case (state_q)
      S_IDLE: begin
        // The done cycle is still the tail of the previous operation.
        if (start && !done_q) begin
          b_d      = base;
          e_d      = exp;
          n_d      = modulus;
          acc_d    = {{(WIDTH-1){1'b0}}, (modulus > WIDTH'(1))};
          sq_d     = '0;
          pr_d     = '0;
          cnt_d    = '0;
          bitcnt_d = '0;
          busy_d   = 1'b1;
          err_d    = 1'b0;
          state_d  = (modulus == '0) ? S_FIN : S_PREP;
        end
      end

      S_PREP: begin
        sq_d  = red_step;
        b_d   = b_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          b_d     = red_step[WIDTH-1:0];
          sq_d    = '0;
          cnt_d   = '0;
          state_d = S_MULT;
`ifdef MODEXP_EARLY_EXIT_EN
          if (e_q == '0) state_d = S_FIN;
`endif
        end
      end

      S_MULT: begin
        sq_d  = sq_step;
        pr_d  = pr_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          b_d      = sq_step[WIDTH-1:0];
          if (e_q[0]) acc_d = pr_step[WIDTH-1:0];
          e_d      = e_next;
          bitcnt_d = bitcnt_q + CW'(1);
          sq_d     = '0;
          pr_d     = '0;
          cnt_d    = '0;
          if (mult_exit) state_d = S_FIN;
        end
      end

      S_FIN: begin
        done_d   = 1'b1;
        busy_d   = 1'b0;
        err_d    = (n_q == '0);
        result_d = (n_q == '0) ? '0 : acc_q;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      b_q      <= '0;
      acc_q    <= '0;
      e_q      <= '0;
      n_q      <= '0;
      sq_q     <= '0;
      pr_q     <= '0;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      e_q      <= e_d;
      n_q      <= n_d;
      sq_q     <= sq_d;
      pr_q     <= pr_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_rsa_modexp_seq.sv
// +--------------------------------------------------------------------------+
// | tb_rsa_modexp_seq : vector table, random ops against an arithmetic model, |
// | and control sequences (reset mid-run, start while busy / at done).       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_rsa_modexp_seq;

  localparam int W   = 16;
  localparam int LIM = 400;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] base;
  logic [W-1:0] exp;
  logic [W-1:0] modulus;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;

  rsa_modexp_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .base    (base),
    .exp     (exp),
    .modulus (modulus),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] b;
    logic [W-1:0] e;
    logic [W-1:0] m;
    logic [W-1:0] res;
    logic         er;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                              input logic [W-1:0] m);
    longint unsigned r, x, mm;
    int unsigned     ee;
    if (m == 0) return '0;
    mm = longint'(m);
    r  = 1 % mm;
    x  = longint'(b) % mm;
    ee = int'(e);
    while (ee != 0) begin
      if (ee[0]) r = (r * x) % mm;
      x  = (x * x) % mm;
      ee = ee >> 1;
    end
    return W'(r);
  endfunction

  function automatic int exp_lat(input logic [W-1:0] e, input logic [W-1:0] m);
    int k;
    if (m == 0) return 1;
`ifdef MODEXP_EARLY_EXIT_EN
    k = 0;
    for (int i = 0; i < W; i++) if (e[i]) k = i + 1;
`else
    k = W;
`endif
    return 1 + W * (1 + k);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, want);
    end
  endtask

  task automatic launch(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m);
    @(negedge clk);
    base    = b;
    exp     = e;
    modulus = m;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    base    = W'($urandom);
    exp     = W'($urandom);
    modulus = W'($urandom);
  endtask

  // Counts edges until done; optionally pokes start while the engine is busy.
  task automatic wait_done(input bit poke, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (poke) begin
        start   = (lat % 2 == 1) && (lat < 30);
        base    = W'($urandom);
        exp     = W'($urandom);
        modulus = W'($urandom);
      end
    end while (!done && lat < LIM);
    start = 1'b0;
  endtask

  task automatic run_and_check(input string nm, input logic [W-1:0] b, input logic [W-1:0] e,
                               input logic [W-1:0] m, input logic [W-1:0] res, input logic er);
    int lat;
    launch(b, e, m);
    check({nm, "_busy"}, 64'(busy), 64'd1);
    check({nm, "_err_clr"}, 64'(err), 64'd0);
    wait_done(1'b0, lat);
    check({nm, "_lat"}, 64'(lat), 64'(exp_lat(e, m)));
    check({nm, "_res"}, 64'(result), 64'(res));
    check({nm, "_err"}, 64'(err), 64'(er));
    check({nm, "_busy_at_done"}, 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    check({nm, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int           lat;
    int           ndone;
    logic [W-1:0] rb, re, rm;

    vecs[0] = '{b: 16'd65,   e: 16'd17,   m: 16'd3233, res: 16'd2790, er: 1'b0};
    vecs[1] = '{b: 16'd2790, e: 16'd2753, m: 16'd3233, res: 16'd65,   er: 1'b0};
    vecs[2] = '{b: 16'd5000, e: 16'd3,    m: 16'd3233, res: 16'd2493, er: 1'b0};
    vecs[3] = '{b: 16'd2,    e: 16'd10,   m: 16'd1000, res: 16'd24,   er: 1'b0};
    vecs[4] = '{b: 16'd123,  e: 16'd0,    m: 16'd7,    res: 16'd1,    er: 1'b0};
    vecs[5] = '{b: 16'd77,   e: 16'd5,    m: 16'd1,    res: 16'd0,    er: 1'b0};
    vecs[6] = '{b: 16'd9,    e: 16'd0,    m: 16'd1,    res: 16'd0,    er: 1'b0};
    vecs[7] = '{b: 16'd0,    e: 16'd5,    m: 16'd7,    res: 16'd0,    er: 1'b0};
    vecs[8] = '{b: 16'd42,   e: 16'd9,    m: 16'd0,    res: 16'd0,    er: 1'b1};

    rst = 1'b1; start = 1'b0; base = '0; exp = '0; modulus = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].b, vecs[i].e, vecs[i].m, vecs[i].res, vecs[i].er);

    for (int i = 0; i < 16; i++) begin
      rb = W'($urandom);
      re = (i % 4 == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
      rm = (i % 5 == 0) ? W'($urandom_range(1, 20)) : W'($urandom_range(2, 65535));
      run_and_check($sformatf("rand%0d", i), rb, re, rm, ref_modexp(rb, re, rm), 1'b0);
    end

    // Reset in the middle of the multiply phase.
    launch(16'd65, 16'd17, 16'd3233);
    repeat (40) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("midrst_no_done", 64'(ndone), 64'd0);
    run_and_check("after_rst", 16'd2790, 16'd2753, 16'd3233, 16'd65, 1'b0);

    // Start pulses while busy must not disturb the running operation.
    launch(16'd2, 16'd10, 16'd1000);
    wait_done(1'b1, lat);
    check("busy_poke_lat", 64'(lat), 64'(exp_lat(16'd10, 16'd1000)));
    check("busy_poke_res", 64'(result), 64'd24);
    ndone = 0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("busy_poke_no_extra", 64'(ndone), 64'd0);
    check("busy_poke_held", 64'(result), 64'd24);

    // Start during the done cycle is ignored; the following cycle accepts it.
    launch(16'd65, 16'd17, 16'd3233);
    wait_done(1'b0, lat);
    check("at_done_res", 64'(result), 64'd2790);
    start = 1'b1; base = 16'd5000; exp = 16'd3; modulus = 16'd3233;
    @(posedge clk);
    #1;
    check("at_done_ignored", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    check("after_done_accepted", 64'(busy), 64'd1);
    start = 1'b0; base = W'($urandom); exp = W'($urandom); modulus = W'($urandom);
    wait_done(1'b0, lat);
    check("after_done_lat", 64'(lat), 64'(exp_lat(16'd3, 16'd3233)));
    check("after_done_res", 64'(result), 64'd2493);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
